// File: rtl/terminal_writer_if.sv
// rtl/terminal_writer_if.sv - character input and VRAM write channels of terminal_writer
interface terminal_writer_if;
    logic       character_ready;
    logic       character_valid;
    logic [7:0] character_byte;
    logic       write_ready;
    logic       write_valid;
    logic [4:0] write_row;
    logic [6:0] write_col;
    logic [7:0] write_byte;

    modport master (
        output character_ready,
        input  character_valid,
        input  character_byte,
        input  write_ready,
        output write_valid,
        output write_row,
        output write_col,
        output write_byte
    );

    modport slave (
        input  character_ready,
        output character_valid,
        output character_byte,
        output write_ready,
        input  write_valid,
        input  write_row,
        input  write_col,
        input  write_byte
    );
endinterface

// File: rtl/terminal_writer.sv
// rtl/terminal_writer.sv - character stream to VRAM writes with cursor and hardware scrolling
module terminal_writer #(
    parameter int ROWS = 30,
    parameter int COLS = 80
) (
    input  logic                 clk,
    input  logic                 reset_low,
    terminal_writer_if.master    bus,
    output logic [4:0]           top_row,
    output logic [4:0]           cursor_row,
    output logic [6:0]           cursor_col
);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [5:0] ROWS_W   = 6'(ROWS);
    localparam logic [7:0] SPACE    = 8'h20;

    typedef enum logic [1:0] {INIT, IDLE, WRITE, CLEAR} state_t;

    state_t     state, nxt_state;
    logic [4:0] top_q, nxt_top;
    logic [4:0] crow_q, nxt_crow;
    logic [6:0] ccol_q, nxt_ccol;
    logic [4:0] wrow_q, nxt_wrow;
    logic [6:0] wcol_q, nxt_wcol;
    logic [7:0] wbyte_q, nxt_wbyte;
    logic       adv_q, nxt_adv;
    logic       wvalid_q;

    logic       wr_acc;
    logic       do_nl;
    logic [5:0] phys_sum;
    logic [5:0] phys_wrap;
    logic [4:0] phys_row;

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state    <= INIT;
            top_q    <= '0;
            crow_q   <= '0;
            ccol_q   <= '0;
            wrow_q   <= '0;
            wcol_q   <= '0;
            wbyte_q  <= SPACE;
            adv_q    <= 1'b0;
            wvalid_q <= 1'b0;
        end else begin
            state    <= nxt_state;
            top_q    <= nxt_top;
            crow_q   <= nxt_crow;
            ccol_q   <= nxt_ccol;
            wrow_q   <= nxt_wrow;
            wcol_q   <= nxt_wcol;
            wbyte_q  <= nxt_wbyte;
            adv_q    <= nxt_adv;
            // registered so the INIT sweep starts only after reset is released
            wvalid_q <= (nxt_state != IDLE);
        end
    end

    always_comb begin
        phys_sum  = {1'b0, top_q} + {1'b0, crow_q};
        phys_wrap = phys_sum - ROWS_W;
        phys_row  = (phys_sum >= ROWS_W) ? phys_wrap[4:0] : phys_sum[4:0];
        wr_acc    = wvalid_q && bus.write_ready;

        nxt_state = state;
        nxt_top   = top_q;
        nxt_crow  = crow_q;
        nxt_ccol  = ccol_q;
        nxt_wrow  = wrow_q;
        nxt_wcol  = wcol_q;
        nxt_wbyte = wbyte_q;
        nxt_adv   = adv_q;
        do_nl     = 1'b0;

        case (state)
            INIT: begin
                if (wr_acc) begin
                    if (wcol_q == COL_LAST) begin
                        nxt_wcol = '0;
                        if (wrow_q == ROW_LAST) begin
                            nxt_wrow  = '0;
                            nxt_state = IDLE;
                        end else begin
                            nxt_wrow = wrow_q + 5'd1;
                        end
                    end else begin
                        nxt_wcol = wcol_q + 7'd1;
                    end
                end
            end
            IDLE: begin
                if (bus.character_valid) begin
                    if (bus.character_byte >= 8'h20 && bus.character_byte <= 8'h7E) begin
                        nxt_wrow  = phys_row;
                        nxt_wcol  = ccol_q;
                        nxt_wbyte = bus.character_byte;
                        nxt_adv   = 1'b1;
                        nxt_state = WRITE;
                    end else if (bus.character_byte == 8'h0D) begin
                        nxt_ccol = '0;
                    end else if (bus.character_byte == 8'h0A) begin
                        do_nl = 1'b1;
                    end else if (bus.character_byte == 8'h08 && ccol_q != 7'd0) begin
                        nxt_ccol  = ccol_q - 7'd1;
                        nxt_wrow  = phys_row;
                        nxt_wcol  = ccol_q - 7'd1;
                        nxt_wbyte = SPACE;
                        nxt_adv   = 1'b0;
                        nxt_state = WRITE;
                    end
                end
            end
            WRITE: begin
                if (wr_acc) begin
                    if (!adv_q) begin
                        nxt_state = IDLE;
                    end else if (ccol_q < COL_LAST) begin
                        nxt_ccol  = ccol_q + 7'd1;
                        nxt_state = IDLE;
                    end else begin
                        do_nl = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (wr_acc) begin
                    if (wcol_q == COL_LAST) begin
                        nxt_state = IDLE;
                    end else begin
                        nxt_wcol = wcol_q + 7'd1;
                    end
                end
            end
            default: nxt_state = INIT;
        endcase

        // the old top row becomes the new bottom row, so it is the one cleared
        if (do_nl) begin
            nxt_ccol = '0;
            if (crow_q < ROW_LAST) begin
                nxt_crow  = crow_q + 5'd1;
                nxt_state = IDLE;
            end else begin
                nxt_top   = (top_q == ROW_LAST) ? 5'd0 : top_q + 5'd1;
                nxt_wrow  = top_q;
                nxt_wcol  = '0;
                nxt_wbyte = SPACE;
                nxt_state = CLEAR;
            end
        end
    end

    always_comb begin
        bus.character_ready = (state == IDLE);
        bus.write_valid     = wvalid_q;
        bus.write_row       = wrow_q;
        bus.write_col       = wcol_q;
        bus.write_byte      = wbyte_q;
        top_row             = top_q;
        cursor_row          = crow_q;
        cursor_col          = ccol_q;
    end
endmodule
